// File: rtl/lsu_ctrl.sv
// Load/store unit: takes one memory op at a time from EXU control, runs a single
// AXI4-Lite-style read or write, and returns the aligned/extended result to write-back.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [4:0]        i_reg_rd,
  input  logic              i_reg_wen,
  input  logic [31:0]       i_upc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [4:0]        o_reg_rd,
  output logic              o_reg_wen,
  output logic [31:0]       o_upc,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_wvalid,
  input  logic              i_wready,
  input  logic [1:0]        i_bresp,
  input  logic              i_bvalid,
  output logic              o_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, d;
  logic [4:0]        rd_q;
  logic              reg_wen_q, load_q, misal_q, err_q;
  logic              aw_done, w_done, accept, misal, aw_hs, w_hs;
  logic [1:0]        sh;

  assign accept = i_valid && o_ready && (i_ren || i_wen);
  // H/HU need even addresses, W needs word alignment; B is never misaligned
  assign misal  = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                  (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
  assign aw_hs  = o_awvalid && i_awready;
  assign w_hs   = o_wvalid && i_wready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // datapath registers need no reset; every output that could leak them is gated by state
  always_ff @(posedge i_clock) begin
    if (accept) begin
      addr_q    <= i_addr;
      funct3_q  <= i_funct3;
      wdata_q   <= i_wdata;
      rd_q      <= i_reg_rd;
      reg_wen_q <= i_reg_wen;
      o_upc     <= i_upc;
      load_q    <= i_ren;
      misal_q   <= misal;
      err_q     <= 1'b0;
    end
    if (state == R && i_rvalid) begin
      rdata_q <= i_rdata;
      err_q   <= |i_rresp;
    end
    if (state == B && i_bvalid) err_q <= |i_bresp;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = misal ? DONE : (i_ren ? AR : AW_W);
      AR:   if (i_arready) state_nx = R;
      R:    if (i_rvalid) state_nx = DONE;
      AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = B;
      B:    if (i_bvalid) state_nx = DONE;
      DONE: if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sh        = addr_q[1:0];
  assign o_ready   = (state == IDLE);
  assign o_valid   = (state == DONE);
  assign o_arvalid = (state == AR);
  assign o_rready  = (state == R);
  assign o_awvalid = (state == AW_W) && !aw_done;
  assign o_wvalid  = (state == AW_W) && !w_done;
  assign o_bready  = (state == B);
  assign o_araddr  = addr_q;
  assign o_awaddr  = addr_q;
  assign o_wdata   = wdata_q << {sh, 3'b000};
  assign o_reg_rd  = rd_q;
  assign o_fault   = o_valid && (misal_q || err_q);
  assign o_reg_wen = o_valid && reg_wen_q && load_q && !misal_q && !err_q;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   o_wstrb = 4'b0001 << sh;
      2'b01:   o_wstrb = 4'b0011 << sh;
      default: o_wstrb = 4'b1111;
    endcase
  end

  assign d = rdata_q >> {sh, 3'b000};

  always_comb begin
    o_result = '0;
    if (o_valid && load_q && !misal_q) begin
      case (funct3_q)
        3'b000:  o_result = {{24{d[7]}}, d[7:0]};
        3'b001:  o_result = {{16{d[15]}}, d[15:0]};
        3'b100:  o_result = {24'd0, d[7:0]};
        3'b101:  o_result = {16'd0, d[15:0]};
        default: o_result = d;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads of each size, a delayed-W store, misaligned
// access, bus error with write-back stall, and reset in the middle of a read.
module tb_lsu_ctrl;
  logic        i_clock = 0, i_reset = 1;
  logic        i_valid = 0, i_ren = 0, i_wen = 0, i_reg_wen = 0, i_ready = 0;
  logic [2:0]  i_funct3 = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, i_upc = 0, i_rdata = 0;
  logic [4:0]  i_reg_rd = 0;
  logic        i_arready = 0, i_rvalid = 0, i_awready = 0, i_wready = 0, i_bvalid = 0;
  logic [1:0]  i_rresp = 0, i_bresp = 0;
  logic        o_ready, o_valid, o_reg_wen, o_fault;
  logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
  logic [31:0] o_result, o_upc, o_araddr, o_awaddr, o_wdata;
  logic [4:0]  o_reg_rd;
  logic [3:0]  o_wstrb;

  int checks = 0, errors = 0;
  int ar_cyc = 0, aw_hs = 0, w_hs = 0, viol = 0;
  logic awv_q = 0, awr_q = 0, wv_q = 0, wr_q = 0, arv_q = 0, arr_q = 0;
  int lat, s_ar, s_aw, s_w;

  lsu_ctrl dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_ren(i_ren), .i_wen(i_wen), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_reg_rd(i_reg_rd), .i_reg_wen(i_reg_wen), .i_upc(i_upc),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_reg_rd(o_reg_rd),
    .o_reg_wen(o_reg_wen), .o_upc(o_upc), .o_fault(o_fault),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  always #5 i_clock = ~i_clock;

  // inputs only change #1 after posedge, so negedge sees what the next edge samples
  always @(negedge i_clock) begin
    if (o_arvalid) ar_cyc <= ar_cyc + 1;
    if (o_awvalid && i_awready) aw_hs <= aw_hs + 1;
    if (o_wvalid && i_wready) w_hs <= w_hs + 1;
    if (!i_reset && ((awv_q && !awr_q && !o_awvalid) || (wv_q && !wr_q && !o_wvalid) ||
                     (arv_q && !arr_q && !o_arvalid)))
      viol <= viol + 1;
    awv_q <= o_awvalid; awr_q <= i_awready;
    wv_q  <= o_wvalid;  wr_q  <= i_wready;
    arv_q <= o_arvalid; arr_q <= i_arready;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // present an op for one edge; returns #1 after the accept edge
  task automatic send(input logic ren, input logic wen, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    i_valid = 1; i_ren = ren; i_wen = wen; i_funct3 = f3; i_addr = a; i_wdata = wd;
    i_reg_rd = 5'd7; i_reg_wen = 1; i_upc = a + 32'd4;
    @(posedge i_clock); #1;
    i_valid = 0; i_ren = 0; i_wen = 0;
  endtask

  // lat counts edges from the accept edge (inclusive) until o_valid is seen
  task automatic wait_valid(output int l);
    l = 1;
    while (!o_valid && l < 20) begin
      @(posedge i_clock); #1;
      l++;
    end
  endtask

  task automatic retire();
    i_ready = 1;
    @(posedge i_clock); #1;
    i_ready = 0;
    chk("valid_drop", {31'd0, o_valid}, 32'd0);
    chk("ready_back", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] rdata, input logic [31:0] exp);
    i_arready = 1; i_rvalid = 1; i_rresp = 0; i_rdata = rdata;
    send(1, 0, f3, a, 0);
    chk({tag, "_araddr"}, o_araddr, a);
    wait_valid(lat);
    chk({tag, "_result"}, o_result, exp);
    chk({tag, "_wen_fault"}, {30'd0, o_reg_wen, o_fault}, 32'd2);
    retire();
  endtask

  initial begin
    repeat (2) @(posedge i_clock);
    #1;
    chk("reset_state", {24'd0, o_ready, o_valid, o_arvalid, o_rready, o_awvalid,
                        o_wvalid, o_bready, o_fault}, 32'h80);
    chk("reset_wen", {31'd0, o_reg_wen}, 32'd0);
    i_reset = 0;
    @(posedge i_clock); #1;

    // LW, zero-wait slave
    i_arready = 1; i_rvalid = 1; i_rresp = 0; i_rdata = 32'hDEADBEEF;
    send(1, 0, 3'b010, 32'h80000004, 0);
    chk("lw_ready_low", {31'd0, o_ready}, 32'd0);
    chk("lw_araddr", o_araddr, 32'h80000004);
    wait_valid(lat);
    chk("lw_latency", lat, 3);
    chk("lw_result", o_result, 32'hDEADBEEF);
    chk("lw_wen_fault", {30'd0, o_reg_wen, o_fault}, 32'd2);
    chk("lw_rd", {27'd0, o_reg_rd}, 32'd7);
    chk("lw_upc", o_upc, 32'h80000008);
    retire();

    // neither ren nor wen: ignored
    i_valid = 1; i_funct3 = 3'b010; i_addr = 32'h80000000;
    @(posedge i_clock); #1;
    i_valid = 0;
    chk("nop_ignored", {30'd0, o_ready, o_arvalid}, 32'd2);

    load("lb", 3'b000, 32'h80000003, 32'h80FF0000, 32'hFFFFFF80);
    load("lbu", 3'b100, 32'h80000003, 32'h80FF0000, 32'h00000080);
    load("lhu", 3'b101, 32'h80000002, 32'h80FF0000, 32'h000080FF);
    load("lh", 3'b001, 32'h80000002, 32'h80FF0000, 32'hFFFF80FF);

    // SH with W delayed behind AW
    i_awready = 1; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    s_aw = aw_hs; s_w = w_hs;
    send(0, 1, 3'b001, 32'h80000002, 32'h1234ABCD);
    chk("sh_valids", {30'd0, o_awvalid, o_wvalid}, 32'd3);
    chk("sh_awaddr", o_awaddr, 32'h80000002);
    chk("sh_wdata", o_wdata, 32'hABCD0000);
    chk("sh_wstrb", {28'd0, o_wstrb}, 32'hC);
    @(posedge i_clock); #1;
    chk("sh_after_aw", {30'd0, o_awvalid, o_wvalid}, 32'd1);
    repeat (2) begin
      @(posedge i_clock); #1;
    end
    chk("sh_w_held", {o_wvalid, 3'd0, o_wstrb, o_wdata[23:0]}, {1'b1, 3'd0, 4'hC, 24'hCD0000});
    i_wready = 1;
    @(posedge i_clock); #1;
    i_wready = 0;
    chk("sh_in_b", {30'd0, o_bready, o_valid}, 32'd2);
    i_bvalid = 1;
    wait_valid(lat);
    i_bvalid = 0;
    chk("sh_done", {29'd0, o_valid, o_reg_wen, o_fault}, 32'd4);
    chk("sh_result", o_result, 32'd0);
    chk("sh_handshakes", {(aw_hs - s_aw), (w_hs - s_w)}, {32'd1, 32'd1});
    retire();

    // misaligned LW
    s_ar = ar_cyc;
    send(1, 0, 3'b010, 32'h80000001, 0);
    wait_valid(lat);
    chk("mis_latency", lat, 1);
    chk("mis_flags", {29'd0, o_valid, o_reg_wen, o_fault}, 32'd5);
    chk("mis_result", o_result, 32'd0);
    retire();
    chk("mis_no_ar", ar_cyc - s_ar, 0);

    // bus error on read, then write-back stall
    i_arready = 1; i_rvalid = 1; i_rresp = 2'b10; i_rdata = 32'h11223344;
    send(1, 0, 3'b010, 32'h80000008, 0);
    wait_valid(lat);
    i_rresp = 0;
    chk("err_flags", {30'd0, o_reg_wen, o_fault}, 32'd1);
    chk("err_result", o_result, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clock); #1;
      chk("stall_hold", {o_valid, o_ready, o_fault, o_reg_wen, o_result[27:0]},
          {4'b1010, 28'h1223344});
    end
    retire();

    // reset while waiting in R
    i_arready = 1; i_rvalid = 0; i_rdata = 32'hCAFEF00D;
    send(1, 0, 3'b010, 32'h80000010, 0);
    @(posedge i_clock); #1;
    chk("rst_in_r", {31'd0, o_rready}, 32'd1);
    i_rvalid = 1; i_reset = 1;
    @(posedge i_clock); #1;
    i_reset = 0; i_rvalid = 0;
    chk("rst_idle", {28'd0, o_rready, o_ready, o_valid, o_arvalid}, 32'd4);
    load("lw_post", 3'b010, 32'h80000010, 32'h0BADF00D, 32'h0BADF00D);

    chk("axi_valid_rule", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit that sits beside the EXU control stage.
- EXU control retires non-memory ops itself and withholds its valid for loads/stores. This block takes those memory ops, runs one AXI4-Lite-style transaction on the data bus, and hands the aligned, extended result to write-back.
- One outstanding transaction at a time. Valid/ready handshake on both sides.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus data width (fixed at 32; the byte-lane logic assumes 4 lanes)

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  upstream op valid
- o_ready  out  1  block can accept an op
- i_ren  in  1  op is a load
- i_wen  in  1  op is a store
- i_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  effective address (ALU result)
- i_wdata  in  32  store data (rs2)
- i_reg_rd  in  5  destination register
- i_reg_wen  in  1  destination write enable
- i_upc  in  32  next PC passed through
- o_valid  out  1  result valid toward write-back
- i_ready  in  1  write-back accepts result
- o_result  out  32  load data (extended); 0 for stores
- o_reg_rd  out  5  registered rd
- o_reg_wen  out  1  registered wen; forced 0 on fault or store
- o_upc  out  32  registered upc
- o_fault  out  1  misaligned access or bus error response
- o_araddr  out  32  read address channel
- o_arvalid  out  1  read address channel
- i_arready  in  1  read address channel
- i_rdata  in  32  read data channel
- i_rresp  in  2  read data channel
- i_rvalid  in  1  read data channel
- o_rready  out  1  read data channel
- o_awaddr  out  32  write address channel
- o_awvalid  out  1  write address channel
- i_awready  in  1  write address channel
- o_wdata  out  32  write data channel
- o_wstrb  out  4  write data channel
- o_wvalid  out  1  write data channel
- i_wready  in  1  write data channel
- i_bresp  in  2  write response channel
- i_bvalid  in  1  write response channel
- o_bready  out  1  write response channel

Behaviour:
- Reset values:
  - State goes to IDLE.
  - o_ready=1.
  - o_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_fault, o_reg_wen = 0.
  - Datapath registers are don't-care.
- Accept condition: i_valid && o_ready && (i_ren || i_wen).
  - i_valid with neither i_ren nor i_wen is ignored.
  - i_ren && i_wen together is illegal (the bench does not drive it).
- On accept, capture addr, funct3, wdata, rd, reg_wen and upc. o_ready drops the next cycle and stays 0 until the result handshake completes.
- States:
  - IDLE -> AR (load) / AW_W (store) / DONE (misaligned).
  - AR: o_arvalid=1 held until i_arready, then -> R.
  - R: o_rready=1; on i_rvalid latch data and resp -> DONE.
  - AW_W: o_awvalid and o_wvalid raised together, each cleared independently on its own handshake. When both have completed -> B.
  - B: o_bready=1; on i_bvalid latch resp -> DONE.
  - DONE: o_valid=1 until i_ready, then -> IDLE with o_ready=1 on the following cycle. No back-to-back accept in the DONE->IDLE cycle.
- Address: o_araddr and o_awaddr carry the full byte address. Bus data is word-lane aligned.
- Store lanes (sh = addr[1:0]):
  - o_wdata = i_wdata << (8*sh).
  - o_wstrb = 0001 (B), 0011 (H), 1111 (W), each << sh.
- Load data:
  - d = i_rdata >> (8*sh).
  - B sign-extends d[7:0]; H sign-extends d[15:0]; BU/HU zero-extend; W passes d.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - No bus transaction is issued.
  - DONE is reached one cycle after accept, with o_fault=1, o_reg_wen=0 and o_result=0.
- Bus error: rresp!=0 or bresp!=0 gives o_fault=1 and o_reg_wen=0; o_result is still driven with the extended data.
- Stores: o_reg_wen=0 and o_result=0.
- AXI rule: a valid, once raised, never drops before its ready. Payloads are stable while valid is high.
- Latency with a zero-wait slave: load accept->o_valid is 3 cycles (AR, R, DONE). Store is also 3 cycles (AW_W, B, DONE).
- Reset mid-transaction: returns to IDLE immediately and drops all valids. The slave is reset in the same cycle, so no orphan response is expected.

Test Plan:
- LW at 0x80000004, rdata=0xDEADBEEF, zero-wait slave -> araddr=0x80000004; o_result=0xDEADBEEF, o_reg_wen=1, o_fault=0; o_valid 3 cycles after accept.
- LB at 0x80000003, rdata=0x80FF0000 -> o_result=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x80000002 -> 0x000080FF.
- SH 0x1234ABCD at 0x80000002 -> wdata=0xABCD0000, wstrb=0011 shifted to 1100. Slave delays wready by 3 cycles after awready -> single AW and W handshakes; o_valid after bvalid; o_reg_wen=0.
- LW at 0x80000001 -> no arvalid ever asserted; o_valid 1 cycle after accept with o_fault=1, o_reg_wen=0.
- Load with rresp=2'b10 -> o_fault=1, o_reg_wen=0. Then i_ready held 0 for 4 cycles -> o_valid and outputs stable, o_ready stays 0.
- Reset asserted while in R with rvalid pending -> next cycle IDLE, o_rready=0, o_ready=1; a subsequent LW completes normally.
